// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter: word format, register codes, source IDs, grant encoding.
// The optional statistics feature in cdb_arbiter is enabled by defining CDB_ARB_STATS_EN.
package cdb_arbiter_pkg;

   localparam int unsigned CDB_W       = 16;
   localparam logic [15:0] CDB_INVALID = 16'hFFFF;

   localparam int unsigned DEST_MSB  = 15;
   localparam int unsigned DEST_LSB  = 13;
   localparam int unsigned RSPOS_MSB = 12;
   localparam int unsigned RSPOS_LSB = 11;
   localparam int unsigned SRC_BIT   = 10;
   localparam int unsigned DATA_MSB  = 9;
   localparam int unsigned DATA_LSB  = 0;

   localparam logic [2:0] REG_R0 = 3'b100;
   localparam logic [2:0] REG_R1 = 3'b010;
   localparam logic [2:0] REG_R2 = 3'b001;

   localparam logic SRC_ULA  = 1'b1;
   localparam logic SRC_LDSD = 1'b0;

   // Encoding matches the cdb_grant port: bit1 = ULA, bit0 = ULA_ld_sd.
   typedef enum logic [1:0] {
      GntNone = 2'b00,
      GntLdsd = 2'b01,
      GntUla  = 2'b10
   } grant_e;

   function automatic logic word_valid(input logic [CDB_W-1:0] word);
      return word != CDB_INVALID;
   endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Per-source result FIFO: DEPTH entries, synchronous flush, no bypass from push to dout.
// Push while full and pop while empty are ignored.
module cdb_fifo
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [CDB_W-1:0] din,
   output logic [CDB_W-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [CDB_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
      return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign empty   = (count_q == '0);
   assign full    = (count_q == CW'(DEPTH));
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
         end
         if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
         end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: dout is only consumed when the FIFO is non-empty.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter placing ULA and ULA_ld_sd results onto a registered 16-bit CDB.
// Define CDB_ARB_STATS_EN to add saturating conflict and stall-cycle counters.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic [15:0] ula_result,
   input  logic [15:0] ld_sd_result,
   output logic        ula_stall,
   output logic        ld_sd_stall,
   output logic [15:0] cdb,
   output logic [1:0]  cdb_grant
`ifdef CDB_ARB_STATS_EN
   ,
   output logic [15:0] stat_conflicts,
   output logic [15:0] stat_stall_cycles
`endif
);

   logic [CDB_W-1:0] ula_dout, ld_dout;
   logic             ula_empty, ld_empty;
   logic             ula_full, ld_full;
   logic             ula_push, ld_push;
   logic             ula_pop, ld_pop;
   logic             both_ne;

   grant_e           gnt;
   grant_e           grant_q, grant_d;
   logic [CDB_W-1:0] cdb_q, cdb_d;
   logic             last_q, last_d;

   assign ula_push = word_valid(ula_result) && !ula_full;
   assign ld_push  = word_valid(ld_sd_result) && !ld_full;
   assign both_ne  = !ula_empty && !ld_empty;

   cdb_fifo #(
      .DEPTH (DEPTH)
   ) u_ula_fifo (
      .clock (clock),
      .reset (reset),
      .push  (ula_push),
      .pop   (ula_pop),
      .flush (flush),
      .din   (ula_result),
      .dout  (ula_dout),
      .empty (ula_empty),
      .full  (ula_full)
   );

   cdb_fifo #(
      .DEPTH (DEPTH)
   ) u_ld_fifo (
      .clock (clock),
      .reset (reset),
      .push  (ld_push),
      .pop   (ld_pop),
      .flush (flush),
      .din   (ld_sd_result),
      .dout  (ld_dout),
      .empty (ld_empty),
      .full  (ld_full)
   );

   always_comb begin
      gnt = GntNone;
      if (!flush) begin
         if (both_ne) begin
            gnt = (last_q == SRC_LDSD) ? GntUla : GntLdsd;
         end else if (!ula_empty) begin
            gnt = GntUla;
         end else if (!ld_empty) begin
            gnt = GntLdsd;
         end
      end
   end

   assign ula_pop = (gnt == GntUla);
   assign ld_pop  = (gnt == GntLdsd);

   always_comb begin
      cdb_d   = CDB_INVALID;
      grant_d = gnt;
      last_d  = last_q;
      unique case (gnt)
         GntUla: begin
            cdb_d  = ula_dout;
            last_d = SRC_ULA;
         end
         GntLdsd: begin
            cdb_d  = ld_dout;
            last_d = SRC_LDSD;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cdb_q   <= CDB_INVALID;
         grant_q <= GntNone;
         last_q  <= SRC_LDSD;
      end else begin
         cdb_q   <= cdb_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   assign cdb         = cdb_q;
   assign cdb_grant   = grant_q;
   assign ula_stall   = ula_full;
   assign ld_sd_stall = ld_full;

`ifdef CDB_ARB_STATS_EN
   logic [15:0] conf_q, conf_d;
   logic [15:0] stall_cyc_q, stall_cyc_d;

   // Counters sample pre-edge FIFO state and survive flush.
   always_comb begin
      conf_d      = conf_q;
      stall_cyc_d = stall_cyc_q;
      if (both_ne && (conf_q != 16'hFFFF)) begin
         conf_d = conf_q + 16'd1;
      end
      if ((ula_full || ld_full) && (stall_cyc_q != 16'hFFFF)) begin
         stall_cyc_d = stall_cyc_q + 16'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         conf_q      <= '0;
         stall_cyc_q <= '0;
      end else begin
         conf_q      <= conf_d;
         stall_cyc_q <= stall_cyc_d;
      end
   end

   assign stat_conflicts    = conf_q;
   assign stat_stall_cycles = stall_cyc_q;
`endif

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the 16-bit common data bus (CDB) between the two result producers: the R-type ULA and ULA_ld_sd.
- Each producer's results are buffered in a small per-source FIFO. One result per cycle is granted onto a registered CDB, round-robin on conflict.
- A full FIFO asserts a stall back to its producer.
- Sits between the functional units and the reservation station / register file CDB consumers.

Parameters:
- DEPTH, 2, entries per source FIFO; power of two, >=1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered results.
- ula_result  in  16  ULA output word; 16'hFFFF = no result.
- ld_sd_result  in  16  ULA_ld_sd output word; 16'hFFFF = no result.
- ula_stall  out  1  ULA FIFO full; ULA must hold its result.
- ld_sd_stall  out  1  ULA_ld_sd FIFO full; ULA_ld_sd must hold its result.
- cdb  out  16  registered CDB word; 16'hFFFF = bus idle.
- cdb_grant  out  2  registered one-hot, aligned with cdb: bit1 = ULA, bit0 = ULA_ld_sd, 00 = idle.

Behaviour:
- Word format, passed through unmodified:
  - [15:13] one-hot destination (R0=100, R1=010, R2=001)
  - [12:11] RS position
  - [10] source (1 = ULA, 0 = ULA_ld_sd)
  - [9:0] data
- An input is valid iff it is not 16'hFFFF.
- Reset (async): both FIFOs empty, pointers 0, cdb=16'hFFFF, cdb_grant=00, ula_stall=0, ld_sd_stall=0, last_grant=LD_SD (ULA wins the first conflict).
- Reset mid-operation: all buffered results lost, no partial word ever driven.
- Enqueue: at a rising edge, a valid input is written iff that FIFO's count < DEPTH before the edge. An input presented while full is not captured; the producer holds it under stall.
- Stall: stall = (count == DEPTH), a combinational function of registered count. It is not relaxed by a same-cycle pop, which prevents duplicate capture.
- Arbitration, evaluated on the pre-edge FIFO state:
  - Neither FIFO non-empty -> no grant.
  - Exactly one non-empty -> grant it.
  - Both non-empty -> grant the source opposite last_grant; last_grant updates on every grant.
- Output: on the edge, cdb <= head of the granted FIFO and that FIFO pops; cdb_grant <= the granted one-hot. With no grant, cdb <= 16'hFFFF and cdb_grant <= 00. cdb is valid for exactly one cycle per result.
- Latency: captured at edge N, empty competing FIFO -> on cdb after edge N+1. Max wait under continuous conflict is 2*DEPTH cycles.
- Simultaneous push and pop on the same FIFO: both take effect; count unchanged.
- Push into an empty FIFO is not grantable in the same cycle (no bypass).
- Wrap-around: read/write pointers increment modulo DEPTH; count is 0..DEPTH.
- flush: takes priority over enqueue and grant. At the edge both FIFOs empty, cdb <= 16'hFFFF, cdb_grant <= 00, last_grant unchanged.
- Order within each source is strict FIFO. No ordering guarantee between sources.

Optional Feature:
- Macro CDB_ARB_STATS_EN.
- Defined: adds outputs stat_conflicts[15:0] and stat_stall_cycles[15:0], both reset to 0 and saturating at 16'hFFFF.
  - stat_conflicts increments each cycle both FIFOs are non-empty.
  - stat_stall_cycles increments each cycle either stall is high.
  - flush does not clear them.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package holds:
  - CDB_INVALID=16'hFFFF
  - field bit positions (DEST_MSB/LSB, RSPOS_MSB/LSB, SRC_BIT, DATA_MSB/LSB)
  - one-hot register codes REG_R0/R1/R2
  - source IDs SRC_ULA=1, SRC_LDSD=0
- Sub-module cdb_fifo (parameter DEPTH; push, pop, flush, din, dout, empty, full), instantiated once per source. Arbitration and the output register live in cdb_arbiter.

Test Plan:
- Reset, no inputs -> cdb=16'hFFFF, cdb_grant=00, both stalls 0, for 10 cycles.
- Single result: ula_result=16'h4C05 for one cycle, then 16'hFFFF -> cdb=16'h4C05, cdb_grant=10 for exactly one cycle after the next edge, then 16'hFFFF.
- Conflict: ula_result=16'h4C05 and ld_sd_result=16'h9003 in the same cycle, both for one cycle -> cdb 16'h4C05 (grant 10), then 16'h9003 (grant 01) on consecutive cycles.
- Back-pressure: ld_sd_result=16'h9003 held continuously while ULA streams distinct words -> ld_sd FIFO fills, ld_sd_stall=1, grants alternate, no word lost or duplicated, per-source order preserved.
- Flush with both FIFOs holding 2 entries -> next cdb=16'hFFFF, stalls drop, later inputs drain normally.
- Async reset asserted between edges while cdb is valid -> cdb=16'hFFFF immediately. With CDB_ARB_STATS_EN: 3 conflict cycles -> stat_conflicts=3.
